// File: rtl/pc_call_stack.sv
// ============================================================================
// Module   : pc_call_stack
// Purpose  : Program counter with hardware return-address stack (Nibbler fetch).
//            Optional macro PC_STACK_GUARD_EN blocks overflow/underflow and
//            raises a sticky error; otherwise the stack is circular.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_call_stack #(
    parameter int N     = 12,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_n,
    input  logic           inc,
    input  logic           call,
    input  logic           ret,
    input  logic [N-1:0]   load_addr,
    output logic [N-1:0]   address,
    output logic [SPW-1:0] sp,
    output logic           stack_empty,
    output logic           stack_full,
    output logic           stack_err
);

    localparam int             WPW        = $clog2(DEPTH);
    localparam logic [SPW-1:0] c_DEPTH_SP = SPW'(DEPTH);
    localparam logic [WPW-1:0] c_WP_MAX   = WPW'(DEPTH - 1);

    logic [N-1:0]   address_q, address_d;
    logic [SPW-1:0] sp_q, sp_d;
    // Next push slot; equals sp modulo DEPTH until the circular stack wraps.
    logic [WPW-1:0] wp_q, wp_d;
    logic [N-1:0]   stack_q [DEPTH];

    logic           w_full, w_empty, w_push;
    logic [WPW-1:0] w_wp_inc, w_wp_dec;
    logic [N-1:0]   w_ret_addr;

    assign w_full     = (sp_q == c_DEPTH_SP);
    assign w_empty    = (sp_q == '0);
    assign w_wp_inc   = (wp_q == c_WP_MAX) ? '0 : wp_q + WPW'(1);
    assign w_wp_dec   = (wp_q == '0) ? c_WP_MAX : wp_q - WPW'(1);
    assign w_ret_addr = address_q + N'(1);

`ifdef PC_STACK_GUARD_EN
    logic err_q, err_d;
    localparam bit c_GUARD = 1'b1;
`else
    localparam bit c_GUARD = 1'b0;
`endif

    always_comb begin
        address_d = address_q;
        sp_d      = sp_q;
        wp_d      = wp_q;
        w_push    = 1'b0;
`ifdef PC_STACK_GUARD_EN
        err_d     = err_q;
`endif
        if (!load_n) begin
            address_d = load_addr;
        end else if (call) begin
            if (c_GUARD && w_full) begin
`ifdef PC_STACK_GUARD_EN
                err_d = 1'b1;
`endif
            end else begin
                w_push    = 1'b1;
                wp_d      = w_wp_inc;
                address_d = load_addr;
                if (!w_full)
                    sp_d = sp_q + SPW'(1);
            end
        end else if (ret) begin
            if (c_GUARD && w_empty) begin
`ifdef PC_STACK_GUARD_EN
                err_d = 1'b1;
`endif
            end else begin
                wp_d      = w_wp_dec;
                address_d = stack_q[w_wp_dec];
                if (!w_empty)
                    sp_d = sp_q - SPW'(1);
            end
        end else if (inc) begin
            address_d = w_ret_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_q <= '0;
            sp_q      <= '0;
            wp_q      <= '0;
            for (int i = 0; i < DEPTH; i++)
                stack_q[i] <= '0;
        end else begin
            address_q <= address_d;
            sp_q      <= sp_d;
            wp_q      <= wp_d;
            if (w_push)
                stack_q[wp_q] <= w_ret_addr;
        end
    end

`ifdef PC_STACK_GUARD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end
    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

    assign address     = address_q;
    assign sp          = sp_q;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;

endmodule

`default_nettype wire

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: directed plan plus random commands
// checked against a ring-buffer reference model.
`default_nettype none

module tb_pc_call_stack;

    localparam int N     = 12;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int MODN  = 1 << N;
`ifdef PC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           load_n = 1'b1;
    logic           inc = 1'b0;
    logic           call = 1'b0;
    logic           ret = 1'b0;
    logic [N-1:0]   load_addr = '0;
    logic [N-1:0]   address;
    logic [SPW-1:0] sp;
    logic           stack_empty, stack_full, stack_err;

    pc_call_stack #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_n(load_n), .inc(inc), .call(call),
        .ret(ret), .load_addr(load_addr), .address(address), .sp(sp),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int sp;
        int err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: ring of DEPTH slots, count of valid entries, push slot.
    int m_addr, m_sp, m_top, m_err;
    int m_ring [DEPTH];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_sp = 0; m_top = 0; m_err = 0;
        for (int i = 0; i < DEPTH; i++) m_ring[i] = 0;
    endtask

    task automatic model_step(input bit ln, input bit ic, input bit cl, input bit rt, input int la);
        if (!ln) begin
            m_addr = la;
        end else if (cl) begin
            if (GUARD && m_sp == DEPTH) begin
                m_err = 1;
            end else begin
                m_ring[m_top] = (m_addr + 1) % MODN;
                m_top = (m_top + 1) % DEPTH;
                if (m_sp < DEPTH) m_sp++;
                m_addr = la;
            end
        end else if (rt) begin
            if (GUARD && m_sp == 0) begin
                m_err = 1;
            end else begin
                m_top = (m_top + DEPTH - 1) % DEPTH;
                m_addr = m_ring[m_top];
                if (m_sp > 0) m_sp--;
            end
        end else if (ic) begin
            m_addr = (m_addr + 1) % MODN;
        end
    endtask

    task automatic do_cmd(input bit ln, input bit ic, input bit cl, input bit rt, input int la);
        exp_t e;
        @(negedge clk);
        load_n = ln; inc = ic; call = cl; ret = rt; load_addr = N'(la);
        model_step(ln, ic, cl, rt, la);
        e.addr = m_addr; e.sp = m_sp; e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".address"}, int'(address), 0);
        check({tag, ".sp"}, int'(sp), 0);
        check({tag, ".empty"}, int'(stack_empty), 1);
        check({tag, ".full"}, int'(stack_full), 0);
        check({tag, ".err"}, int'(stack_err), 0);
    endtask

    // Asynchronous reset asserted between edges with a command pending.
    task automatic do_reset(input int la);
        @(negedge clk);
        reset = 1'b1; load_n = 1'b1; inc = 1'b1; call = 1'b1; ret = 1'b0; load_addr = N'(la);
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0; inc = 1'b0; call = 1'b0;
    endtask

    // Monitor: one expectation per clock in which a command was issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("address", int'(address), e.addr);
                check("sp", int'(sp), e.sp);
                check("stack_empty", int'(stack_empty), int'(e.sp == 0));
                check("stack_full", int'(stack_full), int'(e.sp == DEPTH));
                check("stack_err", int'(stack_err), e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("power_on");
        reset = 1'b0;

        repeat (5) do_cmd(1, 1, 0, 0, 0);

        do_cmd(0, 0, 0, 0, 'h010);
        do_cmd(1, 0, 1, 0, 'h200);
        do_cmd(1, 0, 0, 1, 0);

        do_cmd(0, 0, 0, 0, 'h040);
        for (int i = 1; i <= 4; i++) do_cmd(1, 0, 1, 0, 'h100 * i + i);
        for (int i = 0; i < 4; i++) do_cmd(1, 0, 0, 1, 0);

        do_cmd(0, 0, 0, 0, 'h0FF);
        do_cmd(0, 1, 1, 0, 'h300);

        do_cmd(0, 0, 0, 0, 'hFFF);
        do_cmd(1, 0, 1, 0, 'h100);
        do_cmd(1, 0, 0, 1, 0);

        do_cmd(1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) do_cmd(1, 1, 1, 1, 'h500 + 16 * i);
        do_cmd(1, 0, 1, 0, 'h400);
        do_cmd(1, 0, 0, 1, 0);
        do_cmd(1, 1, 0, 0, 0);
        do_reset('h777);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset($urandom_range(0, MODN - 1));
            end else begin
                do_cmd(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                       $urandom_range(0, MODN - 1));
            end
        end

        @(negedge clk);
        load_n = 1'b1; inc = 1'b0; call = 1'b0; ret = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_call_stack.md
# pc_call_stack

Program counter with an integrated hardware return-address stack for the Nibbler fetch path. It generalises the basic PC with:
- parametrised address width and stack depth;
- subroutine call/return operations alongside the existing load, increment and hold;
- stack-status outputs.

It drives the program-memory address and is controlled by the instruction decoder.

## Interface
- N, 12: address width in bits (N ≥ 2).
- DEPTH, 4: return-stack entries (DEPTH ≥ 2).
- SPW, $clog2(DEPTH+1): stack-pointer width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- load_n  in  1  active-low absolute jump: address <= load_addr.
- inc  in  1  advance address by 1.
- call  in  1  push return address, jump to load_addr.
- ret  in  1  pop top of stack into address.
- load_addr  in  N  jump/call target.
- address  out  N  current program-memory address (registered).
- sp  out  SPW  number of valid stack entries, 0..DEPTH.
- stack_empty  out  1  sp == 0.
- stack_full  out  1  sp == DEPTH.
- stack_err  out  1  sticky overflow/underflow flag (see Configuration).

## Operation
- Command priority per cycle, highest first: load_n=0 > call > ret > inc > hold.
- The selected command executes; all others in that cycle are ignored. call+ret together executes call only.
- Jump (load_n=0): address <= load_addr. Stack untouched.
- Call: stack[sp] <= address+1 (mod 2^N); sp <= sp+1; address <= load_addr.
- Return: address <= stack[sp-1]; sp <= sp-1.
- Increment: address <= address+1, wrapping 2^N-1 → 0.
- Hold: all state unchanged.
- Stack storage is a DEPTH×N register array. Entry sp-1 is top of stack.
- Return address always wraps: a call at address 2^N-1 pushes 0.
- stack_empty and stack_full are combinational decodes of registered sp.
- Overflow (call with sp==DEPTH) and underflow (ret with sp==0) behave per Configuration.

## Timing
- Reset (asynchronous, takes effect immediately, independent of clk):
  - address=0, sp=0, stack_empty=1, stack_full=0, stack_err=0.
  - All stack entries cleared to 0.
- Reset asserted mid-operation aborts any command in that cycle. The first command after deassertion is sampled on the next rising edge.
- Latency: every command is visible on address/sp one cycle after the sampling edge. No multi-cycle operations.
- A ret in the cycle immediately after a call returns the address just pushed; no bubble is required.
- Back-to-back calls fill the stack one entry per cycle. Back-to-back returns drain it one per cycle.

## Configuration
- Macro: PC_STACK_GUARD_EN.
- Defined:
  - Call when full: address, sp and stack unchanged; stack_err <= 1.
  - Return when empty: address and sp unchanged; stack_err <= 1.
  - stack_err stays set until reset.
- Undefined (circular stack):
  - sp stays in 0..DEPTH.
  - Call when full performs the jump and overwrites the oldest entry; sp stays DEPTH; push position rotates modulo DEPTH.
  - Return when empty still jumps, to the entry at the rotated top position; sp stays 0.
  - stack_err is tied to 0.
- Both builds are identical when no overflow or underflow occurs.

## Test plan
- Reset then 5 cycles inc=1 → address 0,1,2,3,4,5; sp=0; stack_empty=1.
- With address=0x010: call, load_addr=0x200 → address=0x200, sp=1. Then ret → address=0x011, sp=0.
- Nested: 4 calls at distinct addresses, then 4 rets → return addresses come back in LIFO order; stack_full=1 after the 4th call.
- With address=0x0FF: load_n=0, inc=1, call=1, load_addr=0x300 → address=0x300, sp unchanged (jump wins).
- With address=0xFFF: call to 0x100, then ret → address=0x000 (wrap).
- Fill the stack, then a 5th call to 0x400:
  - With PC_STACK_GUARD_EN: address holds, stack_err=1 and stays set after a later valid ret; reset mid-sequence clears address, sp and stack_err within the same cycle.
  - Without PC_STACK_GUARD_EN: address=0x400, sp=4.
